// File: rtl/demux_pkg.sv
// Shared types and constants for the bit-level demux/collector
// and the 16:1 bit-select mux that consumes its words.
package demux_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam int DEMUX_WIDTH = 16;

endpackage

// File: rtl/demux16_collect.sv
// Collects addressed single-bit writes into a word and emits it
// through a valid/ready register once every position is filled.
module demux16_collect
  import demux_pkg::*;
#(
  parameter  int WIDTH = DEMUX_WIDTH,
  localparam int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [SEL_W-1:0] in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             dup_err
);

  state_t           state_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             dup_err_q;

  logic [WIDTH-1:0] sel_oh;
  logic             accept;
  logic             complete;
  logic             handshake;
  logic             out_free;
  logic             dup_hit;

  always_comb begin
    sel_oh    = {{(WIDTH-1){1'b0}}, 1'b1} << in_sel;
    in_ready  = (state_q == COLLECT);
    accept    = in_valid && in_ready;
    mask_d    = mask_q | sel_oh;
    data_d    = in_bit ? (data_q | sel_oh)
                       : (data_q & ~sel_oh);
    complete  = accept && (&mask_d);
    handshake = out_valid_q && out_ready;
    out_free  = !out_valid_q || out_ready;
    dup_hit   = accept && (|(mask_q & sel_oh));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      data_q      <= '0;
      mask_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      dup_err_q   <= 1'b0;
    end else begin
      dup_err_q <= dup_hit;
      case (state_q)
        COLLECT: begin
          if (handshake) out_valid_q <= 1'b0;
          // a loading word overrides the handshake clear
          if (complete && out_free) begin
            out_q       <= data_d;
            out_valid_q <= 1'b1;
            data_q      <= '0;
            mask_q      <= '0;
          end else if (complete) begin
            data_q  <= data_d;
            mask_q  <= mask_d;
            state_q <= HOLD;
          end else if (accept) begin
            data_q <= data_d;
            mask_q <= mask_d;
          end
        end
        HOLD: begin
          if (handshake) begin
            out_q   <= data_q;
            data_q  <= '0;
            mask_q  <= '0;
            state_q <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign dup_err   = dup_err_q;

endmodule

// File: tb/tb_demux16_collect.sv
// Directed plus randomized checks of demux16_collect against a
// word-level reference model and an emitted-word scoreboard.
module tb_demux16_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_bit;
  logic [3:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        dup_err;

  demux16_collect #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .dup_err   (dup_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: partial word, output slot, held word
  logic [15:0] m_data, m_mask, m_out, m_hword;
  logic        m_ovalid, m_held, m_dup;
  logic [15:0] sb[$];
  int          pushed, emitted, dup_seen;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_mask = '0; m_out = '0; m_hword = '0;
    m_ovalid = 1'b0; m_held = 1'b0; m_dup = 1'b0;
    sb.delete();
    pushed = 0; emitted = 0;
  endtask

  task automatic model_step(input logic v, input logic b,
                            input logic [3:0] s, input logic ordy);
    logic hs;
    logic [15:0] w;
    hs = m_ovalid && ordy;
    m_dup = 1'b0;
    if (m_held) begin
      if (hs) begin
        m_out  = m_hword;
        m_held = 1'b0;
      end
    end else begin
      if (v) begin
        m_dup = m_mask[s];
        m_data[s] = b;
        m_mask[s] = 1'b1;
      end
      if (v && m_mask == 16'hFFFF) begin
        w = m_data;
        sb.push_back(w);
        pushed++;
        m_data = '0;
        m_mask = '0;
        if (!m_ovalid || hs) begin
          m_out = w;
          m_ovalid = 1'b1;
        end else begin
          m_held = 1'b1;
          m_hword = w;
        end
      end else if (hs) begin
        m_ovalid = 1'b0;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic b,
                     input logic [3:0] s, input logic ordy);
    logic [15:0] w;
    in_valid = v; in_bit = b; in_sel = s; out_ready = ordy;
    #3;
    if (out_valid && ordy) begin
      chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        w = sb.pop_front();
        chk("sb_word", 64'(out), 64'(w));
        emitted++;
      end
    end
    @(posedge clk);
    model_step(v, b, s, ordy);
    #1;
    if (dup_err) dup_seen++;
    chk("in_ready", 64'(in_ready), 64'(!m_held));
    chk("out_valid", 64'(out_valid), 64'(m_ovalid));
    if (m_ovalid) chk("out", 64'(out), 64'(m_out));
    chk("dup_err", 64'(dup_err), 64'(m_dup));
  endtask

  task automatic wr(input logic [3:0] s, input logic b,
                    input logic ordy);
    cyc(1'b1, b, s, ordy);
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 1'b0, 4'd0, ordy);
  endtask

  task automatic fill(input logic [15:0] w, input logic ordy);
    for (int i = 0; i < 16; i++) wr(4'(i), w[i], ordy);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
    in_sel = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_dup_err", 64'(dup_err), 64'd0);
  endtask

  initial begin
    logic [15:0] w, w1, w2;
    int cand[$];
    int ncyc;
    logic [3:0] s;

    do_reset();

    // in-order fill, handshake on the first valid cycle
    w = 16'hA5C3;
    fill(w, 1'b1);
    chk("fill_out", 64'(out), 64'hA5C3);
    chk("fill_valid", 64'(out_valid), 64'd1);
    idle(1'b1);
    chk("fill_drained", 64'(out_valid), 64'd0);

    // reverse order with a duplicate on bit 7
    w = 16'h3C96;
    dup_seen = 0;
    for (int i = 15; i >= 0; i--) begin
      wr(4'(i), w[i], 1'b1);
      if (i == 7) begin
        wr(4'd7, ~w[7], 1'b1);
        chk("dup_pulse", 64'(dup_err), 64'd1);
      end
    end
    chk("rev_out", 64'(out), 64'h3C16);
    chk("dup_once", 64'(dup_seen), 64'd1);
    idle(1'b1);

    // backpressure: second word waits in HOLD
    w1 = 16'h1234; w2 = 16'hBEEF;
    fill(w1, 1'b0);
    fill(w2, 1'b0);
    chk("bp_hold_ready", 64'(in_ready), 64'd0);
    idle(1'b0);
    chk("bp_out1", 64'(out), 64'(w1));
    idle(1'b1);
    chk("bp_out2", 64'(out), 64'(w2));
    chk("bp_valid_kept", 64'(out_valid), 64'd1);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    idle(1'b1);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // completing write coincides with handshake
    w1 = 16'h0F0F; w2 = 16'hC001;
    fill(w1, 1'b0);
    for (int i = 0; i < 15; i++) wr(4'(i), w2[i], 1'b0);
    wr(4'd15, w2[15], 1'b1);
    chk("sim_out", 64'(out), 64'(w2));
    chk("sim_no_hold", 64'(in_ready), 64'd1);
    idle(1'b1);

    // reset after a partial word
    w = 16'hFFFF;
    for (int i = 0; i < 9; i++) wr(4'(i), w[i], 1'b0);
    do_reset();
    w = 16'h5A00;
    fill(w, 1'b0);
    chk("rst_partial_out", 64'(out), 64'h5A00);
    idle(1'b1);

    // reset while in HOLD
    fill(16'h1111, 1'b0);
    fill(16'h2222, 1'b0);
    chk("pre_rst_hold", 64'(in_ready), 64'd0);
    do_reset();
    idle(1'b1);
    idle(1'b1);
    chk("rst_hold_quiet", 64'(out_valid), 64'd0);
    w = 16'h8421;
    fill(w, 1'b0);
    chk("rst_hold_out", 64'(out), 64'h8421);
    idle(1'b1);

    // randomized words against model and scoreboard
    do_reset();
    ncyc = 0;
    while (pushed < 1000 && ncyc < 60000) begin
      cand.delete();
      for (int k = 0; k < 16; k++)
        if (!m_mask[k]) cand.push_back(k);
      if (cand.size() == 0 || $urandom_range(0, 15) == 0)
        s = 4'($urandom_range(0, 15));
      else
        s = 4'(cand[$urandom_range(0, cand.size() - 1)]);
      cyc($urandom_range(0, 9) < 8, 1'($urandom),
          s, 1'($urandom));
      ncyc++;
    end
    chk("rand_words_done", 64'(pushed >= 1000), 64'd1);
    repeat (3) idle(1'b1);
    chk("rand_sb_empty", 64'(sb.size()), 64'd0);
    chk("rand_no_loss", 64'(emitted), 64'(pushed));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
